// File: rtl/reg_file_pkg.sv
// Shared constants and the address type for the register file and its scoreboard.
package reg_file_pkg;

  localparam int unsigned RF_WIDTH = 32;
  localparam int unsigned RF_DEPTH = 32;
  localparam int unsigned RF_NREAD = 2;
  localparam int unsigned RF_AW    = $clog2(RF_DEPTH);

  typedef logic [RF_AW-1:0] reg_adr_t;

endpackage

// File: rtl/sb_popcount.sv
// Combinational population count of the scoreboard pending vector.
module sb_popcount
  import reg_file_pkg::*;
#(
  parameter  int unsigned N  = RF_DEPTH,
  localparam int unsigned CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  vec_i,
  output logic [CW-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < N; i++) begin
      count_o = count_o + CW'(vec_i[i]);
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with write-to-read bypass and a per-register pending
// scoreboard that tracks issued-but-not-written-back destinations.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter  int unsigned WIDTH    = RF_WIDTH,
  parameter  int unsigned DEPTH    = RF_DEPTH,
  parameter  int unsigned NREAD    = RF_NREAD,
  parameter  bit          ZERO_REG = 1'b1,
  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*AW-1:0]    readAdr,
  output logic [NREAD*WIDTH-1:0] readData,
  output logic [NREAD-1:0]       readBusy,
  input  logic                   regWrite,
  input  logic [AW-1:0]          writeAdr,
  input  logic [WIDTH-1:0]       writeData,
  input  logic                   issueValid,
  input  logic [AW-1:0]          issueAdr,
  output logic [CW-1:0]          pendingCount,
  output logic                   wbNoIssue
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] pending_q, pending_d;
  logic [CW-1:0]    count_q, count_d, popcnt_c;
  logic             wb_no_issue_q, wb_no_issue_d;
  logic             wr_ok_c, iss_ok_c;

  // Real storage location: in range and not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    logic ok;
    ok = (32'(a) < 32'(DEPTH));
    if (ZERO_REG && (a == '0)) ok = 1'b0;
    return ok;
  endfunction

  // Reset low gates both writeback and issue, including the bypass path.
  assign wr_ok_c  = rst & regWrite   & addr_ok(writeAdr);
  assign iss_ok_c = rst & issueValid & addr_ok(issueAdr);

  always_comb begin
    readData = '0;
    readBusy = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (addr_ok(readAdr[i*AW +: AW])) begin
        if (wr_ok_c && (writeAdr == readAdr[i*AW +: AW])) begin
          readData[i*WIDTH +: WIDTH] = writeData;
        end else begin
          readData[i*WIDTH +: WIDTH] = regs_q[readAdr[i*AW +: AW]];
          readBusy[i]                = pending_q[readAdr[i*AW +: AW]];
        end
      end
    end
  end

  // Issue is applied after the clear so a same-cycle reissue keeps the reservation.
  always_comb begin
    pending_d     = pending_q;
    wb_no_issue_d = wb_no_issue_q;
    if (wr_ok_c) begin
      if (!pending_q[writeAdr]) wb_no_issue_d = 1'b1;
      pending_d[writeAdr] = 1'b0;
    end
    if (iss_ok_c) pending_d[issueAdr] = 1'b1;
    count_d = popcnt_c;
  end

  sb_popcount #(
    .N (DEPTH)
  ) u_popcount (
    .vec_i   (pending_d),
    .count_o (popcnt_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q     <= '0;
      count_q       <= '0;
      wb_no_issue_q <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      count_q       <= count_d;
      wb_no_issue_q <= wb_no_issue_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_ok_c) begin
      regs_q[writeAdr] <= writeData;
    end
  end

  assign pendingCount = count_q;
  assign wbNoIssue    = wb_no_issue_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed and short random checks of reg_file_sb against a small behavioural model.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  readAdr;
  logic [63:0] readData;
  logic [1:0]  readBusy;
  logic        regWrite;
  logic [4:0]  writeAdr;
  logic [31:0] writeData;
  logic        issueValid;
  logic [4:0]  issueAdr;
  logic [5:0]  pendingCount;
  logic        wbNoIssue;

  logic [4:0]  d2_readAdr;
  logic [31:0] d2_readData;
  logic [0:0]  d2_readBusy;
  logic        d2_regWrite;
  logic [4:0]  d2_writeAdr;
  logic [31:0] d2_writeData;
  logic        d2_issueValid;
  logic [4:0]  d2_issueAdr;
  logic [4:0]  d2_pendingCount;
  logic        d2_wbNoIssue;

  int n_cmp = 0;
  int n_bad = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  logic [31:0] m_regs [32];
  logic [31:0] m_pend;
  logic        m_err;

  always #5 clk = ~clk;

  reg_file_sb dut (
    .clk          (clk),
    .rst          (rst),
    .readAdr      (readAdr),
    .readData     (readData),
    .readBusy     (readBusy),
    .regWrite     (regWrite),
    .writeAdr     (writeAdr),
    .writeData    (writeData),
    .issueValid   (issueValid),
    .issueAdr     (issueAdr),
    .pendingCount (pendingCount),
    .wbNoIssue    (wbNoIssue)
  );

  reg_file_sb #(
    .WIDTH    (32),
    .DEPTH    (20),
    .NREAD    (1),
    .ZERO_REG (1'b0)
  ) dut2 (
    .clk          (clk),
    .rst          (rst),
    .readAdr      (d2_readAdr),
    .readData     (d2_readData),
    .readBusy     (d2_readBusy),
    .regWrite     (d2_regWrite),
    .writeAdr     (d2_writeAdr),
    .writeData    (d2_writeData),
    .issueValid   (d2_issueValid),
    .issueAdr     (d2_issueAdr),
    .pendingCount (d2_pendingCount),
    .wbNoIssue    (d2_wbNoIssue)
  );

  task automatic push(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    string       tag;
    logic [31:0] exp;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL sb_underflow: observed %h with no expected value queued", obs);
    end else begin
      tag = tag_q.pop_front();
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_bad++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic wr,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (wr && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic m_busy(input logic [4:0] a, input logic wr, input logic [4:0] wa);
    return (a != 5'd0) && m_pend[a] && !(wr && wa == a);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pend = 32'd0;
    m_err  = 1'b0;
  endtask

  // One clock of stimulus: combinational outputs checked before the edge, state after it.
  task automatic step(input string tag, input logic [4:0] ra0, input logic [4:0] ra1,
                      input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                      input logic iss, input logic [4:0] ia);
    readAdr    = {ra1, ra0};
    regWrite   = wr;
    writeAdr   = wa;
    writeData  = wd;
    issueValid = iss;
    issueAdr   = ia;
    push({tag, " rd0"}, m_read(ra0, wr, wa, wd));
    push({tag, " rd1"}, m_read(ra1, wr, wa, wd));
    push({tag, " busy0"}, 32'(m_busy(ra0, wr, wa)));
    push({tag, " busy1"}, 32'(m_busy(ra1, wr, wa)));
    #1;
    pop_cmp(readData[31:0]);
    pop_cmp(readData[63:32]);
    pop_cmp(32'(readBusy[0]));
    pop_cmp(32'(readBusy[1]));
    @(posedge clk);
    #1;
    if (wr && wa != 5'd0) begin
      m_regs[wa] = wd;
      if (!m_pend[wa]) m_err = 1'b1;
      m_pend[wa] = 1'b0;
    end
    if (iss && ia != 5'd0) m_pend[ia] = 1'b1;
    push({tag, " count"}, 32'($countones(m_pend)));
    push({tag, " err"}, 32'(m_err));
    pop_cmp(32'(pendingCount));
    pop_cmp(32'(wbNoIssue));
  endtask

  task automatic idle(input string tag, input logic [4:0] ra0, input logic [4:0] ra1);
    step(tag, ra0, ra1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    readAdr = '0; regWrite = 1'b0; writeAdr = '0; writeData = '0;
    issueValid = 1'b0; issueAdr = '0;
    d2_readAdr = '0; d2_regWrite = 1'b0; d2_writeAdr = '0; d2_writeData = '0;
    d2_issueValid = 1'b0; d2_issueAdr = '0;
    m_reset();

    #12;
    push("rst rd", 32'd0);    pop_cmp(readData[31:0]);
    push("rst busy", 32'd0);  pop_cmp(32'(readBusy));
    push("rst count", 32'd0); pop_cmp(32'(pendingCount));
    push("rst err", 32'd0);   pop_cmp(32'(wbNoIssue));
    rst = 1'b1;
    @(posedge clk);
    #1;

    step("iss5", 5'd5, 5'd3, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5);
    step("byp5", 5'd5, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
    idle("hold5", 5'd5, 5'd0);
    push("hold5 const", 32'hDEADBEEF); pop_cmp(readData[31:0]);

    step("zero", 5'd0, 5'd0, 1'b1, 5'd0, 32'h1234, 1'b1, 5'd0);
    idle("zero_rd", 5'd0, 5'd0);

    step("iss3", 5'd3, 5'd3, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
    step("iss7", 5'd3, 5'd7, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    push("iss7 count const", 32'd2); pop_cmp(32'(pendingCount));
    idle("busy3", 5'd0, 5'd3);
    step("wb3", 5'd0, 5'd3, 1'b1, 5'd3, 32'hA5A5_0003, 1'b0, 5'd0);
    push("wb3 count const", 32'd1); pop_cmp(32'(pendingCount));

    step("iss9", 5'd9, 5'd7, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    step("coll9", 5'd9, 5'd7, 1'b1, 5'd9, 32'hC011_0009, 1'b1, 5'd9);
    push("coll9 count const", 32'd2); pop_cmp(32'(pendingCount));
    idle("after_coll", 5'd9, 5'd7);
    step("waw9", 5'd9, 5'd3, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    push("waw9 err const", 32'd0); pop_cmp(32'(wbNoIssue));

    step("err12", 5'd12, 5'd9, 1'b1, 5'd12, 32'h0000_0C0C, 1'b0, 5'd0);
    for (int i = 0; i < 10; i++) idle("err_idle", 5'd12, 5'd9);
    push("err sticky const", 32'd1); pop_cmp(32'(wbNoIssue));

    for (int i = 0; i < 24; i++) begin
      step("rand", 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)));
    end

    step("pre_rst", 5'd5, 5'd9, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
    readAdr   = {5'd9, 5'd5};
    regWrite  = 1'b1;
    writeAdr  = 5'd5;
    writeData = 32'hFFFF_0005;
    issueValid = 1'b1;
    issueAdr  = 5'd6;
    #2;
    rst = 1'b0;
    #1;
    push("mid_rst rd0", 32'd0);   pop_cmp(readData[31:0]);
    push("mid_rst rd1", 32'd0);   pop_cmp(readData[63:32]);
    push("mid_rst busy", 32'd0);  pop_cmp(32'(readBusy));
    push("mid_rst count", 32'd0); pop_cmp(32'(pendingCount));
    push("mid_rst err", 32'd0);   pop_cmp(32'(wbNoIssue));
    m_reset();
    @(posedge clk);
    #1;
    push("in_rst count", 32'd0); pop_cmp(32'(pendingCount));
    push("in_rst rd0", 32'd0);   pop_cmp(readData[31:0]);
    regWrite = 1'b0; issueValid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("post_rst", 5'd5, 5'd6, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    push("post_rst count const", 32'd1); pop_cmp(32'(pendingCount));

    d2_readAdr = 5'd25; d2_regWrite = 1'b1; d2_writeAdr = 5'd25;
    d2_writeData = 32'hAAAA_AAAA; d2_issueValid = 1'b1; d2_issueAdr = 5'd25;
    #1;
    push("oor rd", 32'd0);   pop_cmp(d2_readData);
    push("oor busy", 32'd0); pop_cmp(32'(d2_readBusy));
    @(posedge clk);
    #1;
    push("oor count", 32'd0); pop_cmp(32'(d2_pendingCount));
    push("oor err", 32'd0);   pop_cmp(32'(d2_wbNoIssue));
    d2_readAdr = 5'd0; d2_regWrite = 1'b0; d2_issueAdr = 5'd0;
    @(posedge clk);
    #1;
    push("r0_iss count", 32'd1); pop_cmp(32'(d2_pendingCount));
    push("r0_iss busy", 32'd1);  pop_cmp(32'(d2_readBusy));
    d2_issueValid = 1'b0; d2_regWrite = 1'b1; d2_writeAdr = 5'd0; d2_writeData = 32'h55;
    #1;
    push("r0_byp rd", 32'h55);  pop_cmp(d2_readData);
    push("r0_byp busy", 32'd0); pop_cmp(32'(d2_readBusy));
    @(posedge clk);
    #1;
    d2_regWrite = 1'b0;
    #1;
    push("r0_wb count", 32'd0); pop_cmp(32'(d2_pendingCount));
    push("r0_wb err", 32'd0);   pop_cmp(32'(d2_wbNoIssue));
    push("r0_wb rd", 32'h55);   pop_cmp(d2_readData);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per register.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers; AW = $clog2(DEPTH).
REQ-003 SHALL have parameter NREAD, default 2, number of read ports.
REQ-004 SHALL have parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port readAdr, input, NREAD*AW, packed read addresses; port i = bits [i*AW +: AW].
REQ-008 SHALL have port readData, output, NREAD*WIDTH, packed read data.
REQ-009 SHALL have port readBusy, output, NREAD, per-port pending flag.
REQ-010 SHALL have port regWrite, input, 1, writeback enable.
REQ-011 SHALL have port writeAdr, input, AW, writeback address.
REQ-012 SHALL have port writeData, input, WIDTH, writeback data.
REQ-013 SHALL have port issueValid, input, 1, reserve a destination register.
REQ-014 SHALL have port issueAdr, input, AW, destination to reserve.
REQ-015 SHALL have port pendingCount, output, $clog2(DEPTH+1), number of pending registers.
REQ-016 SHALL have port wbNoIssue, output, 1, sticky error flag.

Function
REQ-017 SHALL drive readData[i] combinationally from register[readAdr[i]], with no added latency.
REQ-018 SHALL bypass: when regWrite and writeAdr==readAdr[i], readData[i] = writeData in the same cycle.
REQ-019 SHALL write writeData into register[writeAdr] at the clock edge when regWrite=1.
REQ-020 With ZERO_REG=1, SHALL return 0 on reads of address 0, ignore writes to 0, apply no bypass at 0, and never set pending[0].
REQ-021 SHALL keep a DEPTH-bit pending vector: issueValid sets pending[issueAdr]; regWrite clears pending[writeAdr].
REQ-022 On simultaneous issue and write to the same address, SHALL write the data and leave pending set (set wins, newer producer).
REQ-023 SHALL drive readBusy[i] = pending[readAdr[i]] AND NOT (regWrite AND writeAdr==readAdr[i]).
REQ-024 SHALL keep readBusy[i] at 0 for address 0 when ZERO_REG=1.
REQ-025 SHALL treat an issue to an already-pending register as legal (WAW): no count change, no error.
REQ-026 SHALL register pendingCount and update it each edge to equal the popcount of the next pending vector; net change is within -1..+1.
REQ-027 SHALL set wbNoIssue at the edge where regWrite targets a non-pending, non-zero register; it stays set until reset.
REQ-028 SHALL ignore out-of-range addresses (>= DEPTH, non-power-of-two DEPTH): reads return 0, writes and issues are ignored.
REQ-029 Read ports SHALL be independent; any ports may address the same register.

Reset
REQ-030 On rst=0, SHALL immediately clear all registers, the pending vector, pendingCount and wbNoIssue, regardless of clk.
REQ-031 While rst=0, SHALL ignore regWrite and issueValid; readData = 0, except writeData via the bypass path, which is gated off during reset.
REQ-032 Reset asserted mid-operation SHALL discard all outstanding reservations; the first edge after release behaves as from an empty scoreboard.

Structure
REQ-033 SHALL place the default-width and depth constants and the address typedef in a shared package, reg_file_pkg, used with the pipeline.
REQ-034 SHALL use one sub-module, sb_popcount, a combinational popcount of the DEPTH-bit vector feeding pendingCount.
REQ-035 SHALL fit in 120-400 lines of RTL; the storage array is inferred as flops, not a macro.

Verification
REQ-036 Reset: drop rst mid-cycle with registers holding data -> all readData = 0 and pendingCount = 0 immediately, without waiting for clk.
REQ-037 Bypass: write 0xDEADBEEF to r5 while readAdr[0]=5 -> readData[0] = 0xDEADBEEF in the same cycle; r5 holds it after the edge.
REQ-038 Zero register: write 0x1234 to r0 and issue to r0 -> readData = 0, readBusy = 0, pendingCount unchanged, wbNoIssue = 0.
REQ-039 Scoreboard: issue r3 then r7 -> pendingCount = 2; readAdr[1]=3 gives busy = 1; write r3 -> busy = 0 in the same cycle and count = 1 after the edge.
REQ-040 Collision: issue r9 and write r9 in the same cycle, r9 previously pending -> data written, pending[9] remains 1, count unchanged.
REQ-041 Error: write r12 with no prior issue -> wbNoIssue = 1 after the edge and still 1 after 10 idle cycles; clears only on rst.
